rw_context_scheduler: RTL and testbench
=======================================

Name: rw_context_scheduler

Overview:
- Time-multiplexes one compiled resumption-machine step core among N independent requesters. The core has a 1-bit input, a 1-bit output, a TAG_W resumption tag and a continue flag.
- Holds a saved resumption tag (context) per requester and picks at most one requester per cycle, round-robin.
- Drives the saved tag and the requester's input bit into the core, then writes the core's next tag back to that requester's context.
- Sits between N stream clients and a single core instance, which is used purely as a combinational step function (core tag register bypassed).

Parameters:
- N, 4, number of requesters (2..8).
- TAG_W, 3, resumption tag width.
- TAG_RST, 3'h4, initial tag loaded into every context at reset and on restart.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N  requester i presents an input bit.
- req_data  in  N  input bit of requester i.
- req_ready  out  N  requester i accepted this cycle (one-hot or zero).
- restart  in  N  reload context i with TAG_RST and clear its done flag.
- rsp_valid  out  N  one-cycle pulse: output for requester i is valid.
- rsp_data  out  N  output bit for requester i.
- rsp_done  out  N  level: requester i's machine has halted (continue returned 0).
- dev_in  out  1  input bit to core.
- dev_tag  out  TAG_W  current resumption tag to core.
- dev_out  in  1  core output bit.
- dev_tag_next  in  TAG_W  core next tag.
- dev_continue  in  1  core continue flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). All state updates occur on the posedge of clk.
- Reset (rst=1 at posedge):
  - every ctx[i] = TAG_RST; done[i] = 0.
  - RR pointer last = N-1, so requester 0 has first priority.
  - rsp_valid = 0, rsp_data = 0, rsp_done = 0.
  - req_ready is combinational and is 0 while rst=1.
- Eligibility: elig[i] = req_valid[i] & ~done[i] & ~restart[i] & ~rst.
- Arbitration (combinational):
  - grant = first eligible index searching last+1, last+2, ... mod N.
  - req_ready = one-hot(grant), or all-zero if nothing is eligible.
  - req_ready may depend combinationally on req_valid.
- Core drive (combinational):
  - with a grant g: dev_in = req_data[g], dev_tag = ctx[g].
  - with no grant: dev_in = 0, dev_tag = TAG_RST.
- Update at posedge when grant g exists:
  - ctx[g] <= dev_tag_next; last <= g.
  - rsp_valid <= one-hot(g); rsp_data[g] <= dev_out.
  - done[g] <= ~dev_continue.
  - Latency: accept in cycle T, response pulse visible in cycle T+1. No response backpressure.
- With no grant: rsp_valid <= 0; last holds; rsp_data holds its previous value.
- States per requester:
  - RUN (done=0) goes to HALT (done=1) when a granted step returns dev_continue=0. The output of that final step is still delivered with rsp_valid.
  - HALT goes to RUN only via restart, which also sets ctx = TAG_RST.
  - rsp_done mirrors done (registered).
- Restart:
  - restart[i] takes effect at the next posedge.
  - It masks requester i from arbitration in the same cycle (restart wins over grant); a pending req_valid[i] waits.
  - Multiple restarts in one cycle are all applied.
  - Restart of an idle RUN requester simply reloads TAG_RST.
- Fairness: a continuously valid requester is granted at least once every N cycles.
- Reset mid-operation: in-flight responses are dropped (rsp_valid = 0 in the cycle after reset) and all contexts are reloaded.
- Only the granted context changes per cycle. Non-granted contexts are bit-exactly preserved.

Test Plan:
- Bench core model for all scenarios: dev_tag_next = dev_tag+1 mod 8; dev_out = dev_in ^ dev_tag[0]; dev_continue = (dev_tag != 7). N=2, TAG_W=3, TAG_RST=4.
- Single requester: after reset, req_valid[0]=1, data=1 for 3 cycles.
  - dev_tag = 4, 5, 6 in successive cycles.
  - rsp_data[0] = 1, 0, 1 one cycle later each.
  - ctx[0] = 7 afterwards.
- Halt: continue from the previous case for one more cycle.
  - The step runs with tag 7, dev_continue=0; rsp_valid[0] pulses with data 1^1 = 0.
  - rsp_done[0] = 1 from the next cycle.
  - req_ready[0] stays 0 thereafter even with req_valid[0]=1.
- Round-robin: both requesters valid continuously.
  - grants alternate 0, 1, 0, 1.
  - Each context advances independently: ctx[0] 4→5→6, ctx[1] 4→5→6.
- Restart collision: restart[1]=1 together with req_valid[1]=1 and ctx[1]=6.
  - req_ready[1] = 0 that cycle; ctx[1] becomes 4 and done[1] = 0.
  - The next grant to requester 1 drives dev_tag = 4.
- Reset mid-stream: assert rst for 1 cycle while both requesters are streaming.
  - Next cycle: rsp_valid = 00, rsp_done = 00, both ctx = 4.
  - The first grant after rst deasserts goes to requester 0.
- Idle: no req_valid.
  - dev_tag = 4, dev_in = 0, rsp_valid = 0.
  - Contexts unchanged over 10 cycles.

Source files
------------

// File: rtl/rw_context_scheduler_if.sv
// Bundle of every client-facing, core-facing and debug signal of the
// resumption-machine context scheduler.
//
// Handshake semantics: a requester step is transferred in a cycle exactly
// when req_valid[i] and req_ready[i] are both 1 at the rising edge of clk.
// req_ready is combinational, is at most one-hot, and may depend on
// req_valid in the same cycle. A requester holding req_valid high keeps
// its data stable until it sees req_ready. Responses have no back-pressure:
// rsp_valid[i] is a single-cycle pulse in the cycle after the transfer, and
// the receiving side must take it then.
interface rw_context_scheduler_if #(
    parameter int N     = 4,
    parameter int TAG_W = 3
) ();

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    // Requester side
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_data;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       restart;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_data;
    logic [N-1:0]       rsp_done;

    // Core side (the core is used as a pure combinational step function)
    logic               dev_in;
    logic [TAG_W-1:0]   dev_tag;
    logic               dev_out;
    logic [TAG_W-1:0]   dev_tag_next;
    logic               dev_continue;

    // Debug view of internal state: all saved contexts packed with
    // requester i at [i*TAG_W +: TAG_W], plus the round-robin pointer.
    logic [N*TAG_W-1:0] ctx_state;
    logic [LW-1:0]      last_grant;

    // Scheduler side
    modport slave (
        input  req_valid, req_data, restart,
        output req_ready, rsp_valid, rsp_data, rsp_done,
        output dev_in, dev_tag,
        input  dev_out, dev_tag_next, dev_continue,
        output ctx_state, last_grant
    );

    // Environment side: requesters plus the step core
    modport master (
        output req_valid, req_data, restart,
        input  req_ready, rsp_valid, rsp_data, rsp_done,
        input  dev_in, dev_tag,
        output dev_out, dev_tag_next, dev_continue,
        input  ctx_state, last_grant
    );

endinterface

// File: rtl/rw_context_scheduler.sv
// Round-robin context scheduler that time-multiplexes one combinational
// resumption-machine step core among N requesters. Each requester owns a
// saved resumption tag and a RUN/HALT state; one granted requester per
// cycle steps the core and gets its context written back.
module rw_context_scheduler #(
    parameter int               N       = 4,
    parameter int               TAG_W   = 3,
    parameter logic [TAG_W-1:0] TAG_RST = 3'h4
) (
    input  logic                  clk,
    input  logic                  rst,
    rw_context_scheduler_if.slave bus
);

    localparam int LW = (N > 1) ? $clog2(N) : 1;

    // Per-requester machine state: RUN steps normally, HALT waits for restart.
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } run_state_t;

    // Registered state
    run_state_t       state_q   [N];
    logic [TAG_W-1:0] ctx_q     [N];
    logic [LW-1:0]    last_q;
    logic [N-1:0]     rsp_valid_q;
    logic [N-1:0]     rsp_data_q;

    // Next-state values
    run_state_t       state_d   [N];
    logic [TAG_W-1:0] ctx_d     [N];
    logic [LW-1:0]    last_d;
    logic [N-1:0]     rsp_valid_d;
    logic [N-1:0]     rsp_data_d;

    // Arbitration results
    logic [N-1:0]     elig;
    logic             grant_valid;
    logic [LW-1:0]    grant_idx;

    // Eligibility: restart and reset both veto a grant; halted machines wait.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = bus.req_valid[i] & (state_q[i] == RUN) & ~bus.restart[i] & ~rst;
        end
    end

    // Round-robin search starting just after the last granted index.
    always_comb begin
        logic [LW:0]   sum;
        logic [LW-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, last_q} + (LW+1)'(k);
            if (sum >= (LW+1)'(N)) begin
                sum = sum - (LW+1)'(N);
            end
            cand = sum[LW-1:0];
            if (!grant_valid && elig[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // State register: contexts, per-requester FSM, RR pointer, response regs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= RUN;
                ctx_q[i]   <= TAG_RST;
            end
            last_q      <= LW'(N - 1);
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                ctx_q[i]   <= ctx_d[i];
            end
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Next-state logic: restarts reload contexts; the granted step writes
    // back the core's next tag. A restarted index is never granted, so the
    // two updates never target the same context.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            ctx_d[i]   = ctx_q[i];
        end
        last_d      = last_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        for (int i = 0; i < N; i++) begin
            if (bus.restart[i]) begin
                state_d[i] = RUN;
                ctx_d[i]   = TAG_RST;
            end
        end

        if (grant_valid) begin
            ctx_d[grant_idx]       = bus.dev_tag_next;
            state_d[grant_idx]     = bus.dev_continue ? RUN : HALT;
            last_d                 = grant_idx;
            rsp_valid_d[grant_idx] = 1'b1;
            rsp_data_d[grant_idx]  = bus.dev_out;
        end
    end

    // Outputs: grant one-hot, core drive, registered responses and debug view.
    always_comb begin
        bus.req_ready = '0;
        bus.dev_in    = 1'b0;
        bus.dev_tag   = TAG_RST;
        if (grant_valid) begin
            bus.req_ready[grant_idx] = 1'b1;
            bus.dev_in               = bus.req_data[grant_idx];
            bus.dev_tag              = ctx_q[grant_idx];
        end

        bus.rsp_valid = rsp_valid_q;
        bus.rsp_data  = rsp_data_q;
        bus.rsp_done  = '0;
        bus.ctx_state = '0;
        for (int i = 0; i < N; i++) begin
            bus.rsp_done[i]                  = (state_q[i] == HALT);
            bus.ctx_state[i*TAG_W +: TAG_W]  = ctx_q[i];
        end
        bus.last_grant = last_q;
    end

endmodule

// File: tb/tb_rw_context_scheduler.sv
// Directed bench for rw_context_scheduler with N=2, TAG_W=3, TAG_RST=4 and a
// reference step core: next = tag+1, out = in ^ tag[0], continue = tag != 7.
module tb_rw_context_scheduler;

    localparam int N     = 2;
    localparam int TAG_W = 3;

    logic clk;
    logic rst;

    rw_context_scheduler_if #(.N(N), .TAG_W(TAG_W)) bus ();

    rw_context_scheduler #(
        .N       (N),
        .TAG_W   (TAG_W),
        .TAG_RST (3'h4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and step core stub
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.dev_tag_next = bus.dev_tag + 3'd1;
    assign bus.dev_out      = bus.dev_in ^ bus.dev_tag[0];
    assign bus.dev_continue = (bus.dev_tag != 3'd7);

    // One vector = inputs for a cycle, combinational expectations before the
    // edge, registered expectations after it. ctx is {ctx1, ctx0}.
    typedef struct {
        logic       rst;
        logic [1:0] vld;
        logic [1:0] dat;
        logic [1:0] rs;
        logic [1:0] rdy;
        logic [2:0] tag;
        logic       din;
        logic [1:0] rv;
        logic [1:0] rd;
        logic [1:0] dn;
        logic [5:0] ctx;
    } vec_t;

    vec_t vec_q[$];
    int   tests;
    int   failed;
    int   cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s (step %0d): got %0h expected %0h", name, cur, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] vld, input logic [1:0] dat,
                       input logic [1:0] rs, input logic [1:0] rdy, input logic [2:0] tag,
                       input logic din, input logic [1:0] rv, input logic [1:0] rd,
                       input logic [1:0] dn, input logic [2:0] c1, input logic [2:0] c0);
        vec_t v;
        v.rst = r;   v.vld = vld; v.dat = dat; v.rs = rs;
        v.rdy = rdy; v.tag = tag; v.din = din;
        v.rv  = rv;  v.rd  = rd;  v.dn  = dn;  v.ctx = {c1, c0};
        vec_q.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [1:0] vld, input logic [1:0] dat,
                         input logic [1:0] rs);
        rst           = r;
        bus.req_valid = vld;
        bus.req_data  = dat;
        bus.restart   = rs;
    endtask

    initial begin
        int grants;
        int cycles;

        tests  = 0;
        failed = 0;
        cur    = 0;
        drive(1'b1, 2'b00, 2'b00, 2'b00);

        //   rst vld    dat    rs     rdy    tag din rv     rd     dn     c1 c0
        add(1, 2'b00, 2'b00, 2'b00, 2'b00, 4, 0, 2'b00, 2'b00, 2'b00, 4, 4); // reset
        add(0, 2'b01, 2'b01, 2'b00, 2'b01, 4, 1, 2'b01, 2'b01, 2'b00, 4, 5); // single
        add(0, 2'b01, 2'b01, 2'b00, 2'b01, 5, 1, 2'b01, 2'b00, 2'b00, 4, 6);
        add(0, 2'b01, 2'b01, 2'b00, 2'b01, 6, 1, 2'b01, 2'b01, 2'b00, 4, 7);
        add(0, 2'b01, 2'b01, 2'b00, 2'b01, 7, 1, 2'b01, 2'b00, 2'b01, 4, 0); // halt step
        add(0, 2'b01, 2'b01, 2'b00, 2'b00, 4, 0, 2'b00, 2'b00, 2'b01, 4, 0); // halted
        add(0, 2'b01, 2'b01, 2'b01, 2'b00, 4, 0, 2'b00, 2'b00, 2'b00, 4, 4); // restart
        add(1, 2'b11, 2'b11, 2'b00, 2'b00, 4, 0, 2'b00, 2'b00, 2'b00, 4, 4); // reset
        add(0, 2'b11, 2'b10, 2'b00, 2'b01, 4, 0, 2'b01, 2'b00, 2'b00, 4, 5); // rr 0
        add(0, 2'b11, 2'b10, 2'b00, 2'b10, 4, 1, 2'b10, 2'b10, 2'b00, 5, 5); // rr 1
        add(0, 2'b11, 2'b10, 2'b00, 2'b01, 5, 0, 2'b01, 2'b11, 2'b00, 5, 6); // rr 0
        add(0, 2'b11, 2'b10, 2'b00, 2'b10, 5, 1, 2'b10, 2'b01, 2'b00, 6, 6); // rr 1
        add(0, 2'b11, 2'b10, 2'b10, 2'b01, 6, 0, 2'b01, 2'b00, 2'b00, 4, 7); // restart collide
        add(0, 2'b10, 2'b10, 2'b00, 2'b10, 4, 1, 2'b10, 2'b10, 2'b00, 5, 7); // 1 from TAG_RST
        add(1, 2'b11, 2'b11, 2'b00, 2'b00, 4, 0, 2'b00, 2'b00, 2'b00, 4, 4); // reset mid-stream
        add(0, 2'b11, 2'b11, 2'b00, 2'b01, 4, 1, 2'b01, 2'b01, 2'b00, 4, 5); // 0 first
        for (int k = 0; k < 10; k++) begin
            add(0, 2'b00, 2'b00, 2'b00, 2'b00, 4, 0, 2'b00, 2'b01, 2'b00, 4, 5); // idle
        end
        add(0, 2'b11, 2'b11, 2'b11, 2'b00, 4, 0, 2'b00, 2'b01, 2'b00, 4, 4); // both restart

        foreach (vec_q[i]) begin
            cur = i;
            @(negedge clk);
            drive(vec_q[i].rst, vec_q[i].vld, vec_q[i].dat, vec_q[i].rs);
            #1;
            check("req_ready", 32'(bus.req_ready), 32'(vec_q[i].rdy));
            check("dev_tag",   32'(bus.dev_tag),   32'(vec_q[i].tag));
            check("dev_in",    32'(bus.dev_in),    32'(vec_q[i].din));
            @(posedge clk);
            #1;
            check("rsp_valid", 32'(bus.rsp_valid), 32'(vec_q[i].rv));
            check("rsp_data",  32'(bus.rsp_data),  32'(vec_q[i].rd));
            check("rsp_done",  32'(bus.rsp_done),  32'(vec_q[i].dn));
            check("ctx",       32'(bus.ctx_state), 32'(vec_q[i].ctx));
        end

        // Run requester 0 from TAG_RST to halt: tags 4,5,6,7 means exactly
        // four grants, one per cycle, with done rising after the fourth.
        cur    = vec_q.size();
        grants = 0;
        cycles = 0;
        while (cycles < 20) begin
            @(negedge clk);
            drive(1'b0, 2'b01, 2'b00, 2'b00);
            @(posedge clk);
            #1;
            cycles++;
            if (bus.rsp_valid[0]) grants++;
            if (bus.rsp_done[0]) break;
        end
        check("halt_cycles", 32'(cycles), 32'd4);
        check("halt_grants", 32'(grants), 32'd4);

        @(negedge clk);
        drive(1'b0, 2'b01, 2'b01, 2'b00);
        #1;
        check("halt_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1;
        check("halt_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("halt_ctx",       32'(bus.ctx_state), {26'd0, 3'd4, 3'd0});

        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
